// File: rtl/grs_align_shift_pkg.sv
// rtl/grs_align_shift_pkg.sv - shared constants for the GRS alignment shifter
package grs_align_shift_pkg;

    // Guard, round and sticky bits appended below the mantissa
    localparam int GRS_BITS = 3;

    // FSM state encodings
    localparam logic [1:0] ALIGN_IDLE  = 2'd0;
    localparam logic [1:0] ALIGN_SHIFT = 2'd1;
    localparam logic [1:0] ALIGN_DONE  = 2'd2;

endpackage

// File: rtl/grs_align_shift_if.sv
// rtl/grs_align_shift_if.sv - request/result handshake bundle of the alignment shifter
interface grs_align_shift_if
    import grs_align_shift_pkg::*;
#(
    parameter int MANT_WIDTH  = 24,
    parameter int SHIFT_WIDTH = 8
);
    localparam int W = MANT_WIDTH + GRS_BITS;

    logic                   in_valid;
    logic                   in_ready;
    logic [MANT_WIDTH-1:0]  in_mant;
    logic [SHIFT_WIDTH-1:0] in_shift;
    logic                   in_sign;
    logic                   out_valid;
    logic                   out_ready;
    logic [W-1:0]           out_value;
    logic                   out_sign;

    modport master (
        output in_valid, in_mant, in_shift, in_sign, out_ready,
        input  in_ready, out_valid, out_value, out_sign
    );

    modport slave (
        input  in_valid, in_mant, in_shift, in_sign, out_ready,
        output in_ready, out_valid, out_value, out_sign
    );

endinterface

// File: rtl/grs_align_shift_sticky.sv
// rtl/grs_align_shift_sticky.sv - one bounded right-shift step with sticky jam into bit 0
module grs_sticky_shift #(
    parameter int W        = 27,
    parameter int MAX_STEP = 8,
    parameter int STEP_W   = $clog2(MAX_STEP + 1)
) (
    input  logic [W-1:0]      acc_i,
    input  logic [STEP_W-1:0] step_i,
    output logic [W-1:0]      shifted_o,
    output logic              any_o
);

    // Shift right by step_i; bit 0 becomes the OR of the landing bit and every bit dropped
    always_comb begin
        logic sticky;
        sticky    = 1'b0;
        shifted_o = acc_i >> step_i;
        for (int i = 0; i <= MAX_STEP; i++) begin
            if (i <= int'(step_i)) begin
                sticky = sticky | acc_i[i];
            end
        end
        shifted_o[0] = sticky;
    end

    // Whole-word OR, used when the shift pushes everything into the sticky bit
    assign any_o = |acc_i;

endmodule

// File: rtl/grs_align_shift.sv
// rtl/grs_align_shift.sv - multi-cycle right-shift aligner producing a GRS-extended mantissa
module grs_align_shift
    import grs_align_shift_pkg::*;
#(
    parameter int MANT_WIDTH  = 24,
    parameter int SHIFT_WIDTH = 8,
    parameter int MAX_STEP    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    grs_align_shift_if.slave bus
);

    localparam int W      = MANT_WIDTH + GRS_BITS;
    localparam int STEP_W = $clog2(MAX_STEP + 1);
    localparam logic [31:0]            W_U     = W;
    localparam logic [SHIFT_WIDTH-1:0] MAX_S   = SHIFT_WIDTH'(MAX_STEP);
    localparam logic [STEP_W-1:0]      MAX_STP = STEP_W'(MAX_STEP);

    logic [1:0]             state_q, state_d;
    logic [W-1:0]           acc_q, acc_d;
    logic [SHIFT_WIDTH-1:0] rem_q, rem_d;
    logic                   sign_q, sign_d;

    logic [STEP_W-1:0]      step;
    logic [W-1:0]           sh_in, sh_out;
    logic                   sh_any;
    logic [W-1:0]           mant_ext;
    logic                   saturate;

    assign mant_ext = {bus.in_mant, {GRS_BITS{1'b0}}};
    assign saturate = 32'(bus.in_shift) >= W_U;

    // In IDLE the shifter sees the incoming mantissa so its OR serves the saturate path
    assign sh_in = (state_q == ALIGN_IDLE) ? mant_ext : acc_q;

    // Per-cycle step is the remaining distance clamped to MAX_STEP
    always_comb begin
        step = MAX_STP;
        if (rem_q < MAX_S) begin
            step = STEP_W'(rem_q);
        end
    end

    grs_sticky_shift #(
        .W        (W),
        .MAX_STEP (MAX_STEP),
        .STEP_W   (STEP_W)
    ) u_sticky (
        .acc_i     (sh_in),
        .step_i    (step),
        .shifted_o (sh_out),
        .any_o     (sh_any)
    );

    // Next-state logic: accept in IDLE, shift in SHIFT, hold result in DONE until taken
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        sign_d  = sign_q;
        case (state_q)
            ALIGN_IDLE: begin
                if (bus.in_valid) begin
                    sign_d = bus.in_sign;
                    if (bus.in_shift == '0) begin
                        acc_d   = mant_ext;
                        state_d = ALIGN_DONE;
                    end else if (saturate) begin
                        acc_d   = {{(W-1){1'b0}}, sh_any};
                        state_d = ALIGN_DONE;
                    end else begin
                        acc_d   = mant_ext;
                        rem_d   = bus.in_shift;
                        state_d = ALIGN_SHIFT;
                    end
                end
            end
            ALIGN_SHIFT: begin
                acc_d = sh_out;
                rem_d = rem_q - SHIFT_WIDTH'(step);
                if (rem_q == SHIFT_WIDTH'(step)) begin
                    state_d = ALIGN_DONE;
                end
            end
            ALIGN_DONE: begin
                if (bus.out_ready) begin
                    state_d = ALIGN_IDLE;
                end
            end
            default: state_d = ALIGN_IDLE;
        endcase
    end

    // State registers; reset discards any in-flight result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ALIGN_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            sign_q  <= sign_d;
        end
    end

    assign bus.in_ready  = (state_q == ALIGN_IDLE);
    assign bus.out_valid = (state_q == ALIGN_DONE);
    assign bus.out_value = acc_q;
    assign bus.out_sign  = sign_q;

endmodule

// File: tb/tb_grs_align_shift.sv
// tb/tb_grs_align_shift.sv - directed self-checking bench for grs_align_shift
module tb_grs_align_shift;

    typedef struct {
        logic [23:0] mant;
        logic [7:0]  shift;
        logic        sign;
        logic [26:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    grs_align_shift_if #(.MANT_WIDTH(24), .SHIFT_WIDTH(8)) bus8 ();
    grs_align_shift_if #(.MANT_WIDTH(24), .SHIFT_WIDTH(8)) bus1 ();

    grs_align_shift #(.MANT_WIDTH(24), .SHIFT_WIDTH(8), .MAX_STEP(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    grs_align_shift #(.MANT_WIDTH(24), .SHIFT_WIDTH(8), .MAX_STEP(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input int s, input int ms);
        if (s == 0 || s >= 27) return 1;
        return 1 + (s + ms - 1) / ms;
    endfunction

    function automatic logic [26:0] model(input logic [23:0] m, input logic [7:0] s);
        logic [26:0] x, r, lost;
        x = {m, 3'b000};
        if (s >= 8'd27) return {26'd0, |m};
        r    = x >> s;
        lost = x & ((27'd1 << s) - 27'd1);
        r[0] = r[0] | (|lost);
        return r;
    endfunction

    // Issue one request to both DUTs in lockstep and check value, sign and latency of each
    task automatic run_vec(input vec_t v, input string tag);
        int          lat8, lat1;
        logic [26:0] val8, val1;
        logic        s8, s1;
        bit          seen8, seen1;
        seen8 = 0; seen1 = 0; lat8 = 0; lat1 = 0;
        val8 = '0; val1 = '0; s8 = 0; s1 = 0;
        @(negedge clk);
        chk({tag, " in_ready8"}, 32'(bus8.in_ready), 32'd1);
        chk({tag, " in_ready1"}, 32'(bus1.in_ready), 32'd1);
        bus8.in_valid = 1'b1; bus8.in_mant = v.mant; bus8.in_shift = v.shift; bus8.in_sign = v.sign;
        bus1.in_valid = 1'b1; bus1.in_mant = v.mant; bus1.in_shift = v.shift; bus1.in_sign = v.sign;
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0; bus8.in_mant = ~v.mant; bus8.in_shift = 8'd3; bus8.in_sign = ~v.sign;
        bus1.in_valid = 1'b0; bus1.in_mant = ~v.mant; bus1.in_shift = 8'd3; bus1.in_sign = ~v.sign;
        for (int c = 1; c <= 60 && !(seen8 && seen1); c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (!seen8 && bus8.out_valid) begin
                seen8 = 1; lat8 = c; val8 = bus8.out_value; s8 = bus8.out_sign;
            end
            if (!seen1 && bus1.out_valid) begin
                seen1 = 1; lat1 = c; val1 = bus1.out_value; s1 = bus1.out_sign;
            end
        end
        chk({tag, " done8"}, 32'(seen8), 32'd1);
        chk({tag, " done1"}, 32'(seen1), 32'd1);
        if (seen8) begin
            chk({tag, " value8"}, 32'(val8), 32'(v.exp));
            chk({tag, " sign8"}, 32'(s8), 32'(v.sign));
            chk({tag, " lat8"}, 32'(lat8), 32'(exp_lat(int'(v.shift), 8)));
        end
        if (seen1) begin
            chk({tag, " value1"}, 32'(val1), 32'(v.exp));
            chk({tag, " sign1"}, 32'(s1), 32'(v.sign));
            chk({tag, " lat1"}, 32'(lat1), 32'(exp_lat(int'(v.shift), 1)));
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[14];

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        bus8.in_valid = 0; bus8.in_mant = '0; bus8.in_shift = '0; bus8.in_sign = 0; bus8.out_ready = 1;
        bus1.in_valid = 0; bus1.in_mant = '0; bus1.in_shift = '0; bus1.in_sign = 0; bus1.out_ready = 1;

        vecs[0]  = '{24'hC00001, 8'd0,   1'b1, 27'h6000008};
        vecs[1]  = '{24'h800001, 8'd4,   1'b0, 27'h0400001};
        vecs[2]  = '{24'h800001, 8'd2,   1'b1, 27'h1000002};
        vecs[3]  = '{24'hFFFFFF, 8'd20,  1'b0, 27'h000007F};
        vecs[4]  = '{24'h000001, 8'd27,  1'b1, 27'h0000001};
        vecs[5]  = '{24'h000000, 8'd200, 1'b0, 27'h0000000};
        vecs[6]  = '{24'h400000, 8'd26,  1'b1, 27'h0000001};
        vecs[7]  = '{24'hABCDEF, 8'd12,  1'b0, 27'h00055E7};
        vecs[8]  = '{24'h000001, 8'd1,   1'b0, 27'h0000004};
        vecs[9]  = '{24'h000100, 8'd8,   1'b1, 27'h0000008};
        vecs[10] = '{24'h000101, 8'd9,   1'b0, 27'h0000005};
        vecs[11] = '{24'h800000, 8'd255, 1'b1, 27'h0000001};
        vecs[12] = '{24'h000000, 8'd5,   1'b0, 27'h0000000};
        vecs[13] = '{24'hFFFFFF, 8'd26,  1'b1, 27'h0000001};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready8", 32'(bus8.in_ready), 32'd1);
        chk("rst out_valid8", 32'(bus8.out_valid), 32'd0);
        chk("rst out_value8", 32'(bus8.out_value), 32'd0);
        chk("rst out_sign8", 32'(bus8.out_sign), 32'd0);
        chk("rst in_ready1", 32'(bus1.in_ready), 32'd1);
        chk("rst out_valid1", 32'(bus1.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-rst out_valid8", 32'(bus8.out_valid), 32'd0);

        // Directed table
        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Random vectors against the arithmetic reference
        for (int i = 0; i < 6; i++) begin
            vec_t r;
            r.mant  = 24'($urandom);
            r.shift = 8'($urandom_range(0, 40));
            r.sign  = 1'($urandom);
            r.exp   = model(r.mant, r.shift);
            run_vec(r, $sformatf("rnd%0d", i));
        end

        // Backpressure: result held for 5 cycles, new request refused until taken
        @(negedge clk);
        bus8.out_ready = 1'b0;
        bus8.in_valid = 1'b1; bus8.in_mant = 24'h800001; bus8.in_shift = 8'd4; bus8.in_sign = 1'b1;
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp first out_valid", 32'(bus8.out_valid), 32'd1);
        bus8.in_valid = 1'b1; bus8.in_mant = 24'h123456; bus8.in_shift = 8'd0; bus8.in_sign = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp hold%0d out_valid", k), 32'(bus8.out_valid), 32'd1);
            chk($sformatf("bp hold%0d out_value", k), 32'(bus8.out_value), 32'h0400001);
            chk($sformatf("bp hold%0d out_sign", k), 32'(bus8.out_sign), 32'd1);
            chk($sformatf("bp hold%0d in_ready", k), 32'(bus8.in_ready), 32'd0);
        end
        @(negedge clk);
        bus8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp release in_ready", 32'(bus8.in_ready), 32'd1);
        chk("bp release out_valid", 32'(bus8.out_valid), 32'd0);
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        chk("bp new out_valid", 32'(bus8.out_valid), 32'd1);
        chk("bp new out_value", 32'(bus8.out_value), 32'h091A2B0);
        chk("bp new out_sign", 32'(bus8.out_sign), 32'd0);
        @(posedge clk);
        #1;
        chk("bp back idle", 32'(bus8.in_ready), 32'd1);

        // Reset during the second SHIFT cycle of a shift=20 operation
        @(negedge clk);
        bus8.in_valid = 1'b1; bus8.in_mant = 24'hFFFFFF; bus8.in_shift = 8'd20; bus8.in_sign = 1'b1;
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid in_ready", 32'(bus8.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst out_valid", 32'(bus8.out_valid), 32'd0);
        chk("arst out_value", 32'(bus8.out_value), 32'd0);
        chk("arst out_sign", 32'(bus8.out_sign), 32'd0);
        chk("arst in_ready", 32'(bus8.in_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post-arst%0d out_valid", k), 32'(bus8.out_valid), 32'd0);
            chk($sformatf("post-arst%0d in_ready", k), 32'(bus8.in_ready), 32'd1);
        end
        run_vec(vecs[3], "after-rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
